mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter DIM, default 4, the square matrix dimension (2..16).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(DIM), the index width.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  level, sampled only in IDLE.
REQ-006 The block SHALL have port abort  input  1  cancels the run in progress.
REQ-007 The block SHALL have port busy  output  1  high in every non-IDLE state except DONE.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse at normal completion.
REQ-009 The block SHALL have port rd_en  output  1  operand read strobe to the A/B operand memories.
REQ-010 The block SHALL have ports row_idx, col_idx, k_idx  output  IDX_W each  read address: A[row][k], B[k][col].
REQ-011 The block SHALL have ports acc_clr and acc_en  output  1 each  MAC accumulator clear and accumulate strobes.
REQ-012 The block SHALL have port res_wr_en  output  1  result write strobe; address is row_idx/col_idx.
REQ-013 The block SHALL have port perf_cycles  output  32  busy-cycle count of the last run.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, ISSUE, DRAIN, WRITE, DONE.
REQ-015 IDLE->CLEAR SHALL occur when start=1.
REQ-016 CLEAR SHALL last 1 cycle, assert acc_clr, and then go to ISSUE with k=0.
REQ-017 ISSUE SHALL last DIM cycles, assert rd_en each cycle, and increment k_idx from 0 to DIM-1.
REQ-018 acc_en SHALL be rd_en delayed one cycle, matching the 1-cycle memory read latency.
REQ-019 DRAIN SHALL last 1 cycle, with acc_en high for the last k.
REQ-020 WRITE SHALL last 1 cycle and assert res_wr_en.
REQ-021 At the end of WRITE, col SHALL increment; when col wraps DIM-1->0, row SHALL increment.
REQ-022 WRITE of element (DIM-1,DIM-1) SHALL go to DONE; any other WRITE SHALL go to CLEAR.
REQ-023 DONE SHALL last 1 cycle, assert done, and then go to IDLE.
REQ-024 Each element SHALL take DIM+3 cycles; a full run SHALL take DIM*DIM*(DIM+3) busy cycles.
REQ-025 Strobes SHALL be mutually exclusive per cycle, except that acc_en may coincide with rd_en.
REQ-026 Indices SHALL hold their value outside ISSUE and SHALL never exceed DIM-1.
REQ-027 abort=1 in any busy state SHALL send the FSM to IDLE next cycle; all strobes SHALL be 0 that cycle; done SHALL NOT assert; indices SHALL be 0.
REQ-028 abort SHALL have priority over all other transitions; abort in IDLE or DONE SHALL be ignored.
REQ-029 start while busy SHALL be ignored; start held high SHALL begin a new run immediately after DONE->IDLE.

Reset
REQ-030 RST SHALL put the FSM in IDLE asynchronously and clear all indices, busy, done, rd_en, acc_en, acc_clr, res_wr_en and perf_cycles to 0.
REQ-031 RST asserted mid-run SHALL behave like abort, but with immediate effect; no partial result write SHALL follow.

Configuration
REQ-032 Macro MAC_SEQ_PERF_CNT_EN SHALL control the performance counter.
REQ-033 With the macro defined, the counter SHALL clear on IDLE->CLEAR, increment on every busy cycle, and drive perf_cycles; it SHALL hold its value after done or abort.
REQ-034 Without the macro, perf_cycles SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-035 Package mac_seq_pkg SHALL hold the FSM state encoding, the DIM default, and the PERF_W=32 constant.
REQ-036 Sub-module mac_seq_idx_cnt SHALL implement the nested row/col/k counter with wrap and last-element flags.

Verification
REQ-037 DIM=2, start pulse at cycle 0 -> busy cycles 1..20; res_wr_en at cycles 5,10,15,20; done at cycle 21 only.
REQ-038 DIM=2 run -> (row,col) at the four writes SHALL be (0,0),(0,1),(1,0),(1,1); k_idx sequence per element SHALL be 0,1.
REQ-039 abort during the second ISSUE cycle of element (0,1) -> IDLE next cycle, no done, no further strobes.
REQ-040 RST pulse mid-DRAIN -> all outputs 0 before the next CLK edge; a subsequent start SHALL run a full, correct pass.
REQ-041 start held high over two runs with MAC_SEQ_PERF_CNT_EN defined -> back-to-back runs with perf_cycles=20 each (DIM=2); without the macro, perf_cycles=0.
REQ-042 Random-data scoreboard check: the MAC model fed by the strobes SHALL match the reference matrix product for DIM=4.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the matrix-multiply MAC sequencer: FSM encoding,
// default matrix dimension and performance-counter width.
package mac_seq_pkg;

    localparam int DIM_DEFAULT = 4;
    localparam int PERF_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // DONE is deliberately not busy so that busy covers exactly the counted cycles.
    function automatic logic is_busy(input state_e s);
        return !((s == S_IDLE) || (s == S_DONE));
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Control/strobe bundle between a host (master) and the MAC sequencer (slave).
interface mac_seq_if import mac_seq_pkg::*; #(
    parameter int IDX_W = 2
) ();

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [IDX_W-1:0]  row_idx;
    logic [IDX_W-1:0]  col_idx;
    logic [IDX_W-1:0]  k_idx;
    logic              acc_clr;
    logic              acc_en;
    logic              res_wr_en;
    logic [PERF_W-1:0] perf_cycles;

    modport master (
        output start, abort,
        input  busy, done, rd_en, row_idx, col_idx, k_idx,
        input  acc_clr, acc_en, res_wr_en, perf_cycles
    );

    modport slave (
        input  start, abort,
        output busy, done, rd_en, row_idx, col_idx, k_idx,
        output acc_clr, acc_en, res_wr_en, perf_cycles
    );

endinterface

// File: rtl/mac_seq_idx_cnt.sv
// Nested row/col/k index counter with wrap, flagging the last k and the
// last (DIM-1,DIM-1) element of the matrix.
module mac_seq_idx_cnt #(
    parameter int DIM   = 4,
    parameter int IDX_W = $clog2(DIM)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_all,
    input  logic             k_clr,
    input  logic             k_inc,
    input  logic             rc_inc,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             k_last,
    output logic             elem_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] k_q,   k_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        k_d   = k_q;
        if (clr_all) begin
            row_d = '0;
            col_d = '0;
            k_d   = '0;
        end else begin
            // k saturates at LAST so it can never leave the legal range.
            if (k_clr) begin
                k_d = '0;
            end else if (k_inc && (k_q != LAST)) begin
                k_d = k_q + IDX_W'(1);
            end
            if (rc_inc) begin
                if (col_q == LAST) begin
                    col_d = '0;
                    row_d = (row_q == LAST) ? '0 : row_q + IDX_W'(1);
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            k_q   <= k_d;
        end
    end

    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign k_idx     = k_q;
    assign k_last    = (k_q == LAST);
    assign elem_last = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer for a DIM x DIM matrix product on one MAC: CLEAR/ISSUE/DRAIN/WRITE per
// element. Define MAC_SEQ_PERF_CNT_EN to build the busy-cycle performance counter.
module mac_sequencer import mac_seq_pkg::*; #(
    parameter int DIM   = DIM_DEFAULT,
    parameter int IDX_W = $clog2(DIM)
) (
    input  logic     CLK,
    input  logic     RST,
    mac_seq_if.slave bus
);

    state_e state_q, state_d;
    logic   acc_en_q, acc_en_d;

    logic busy, abort_hit;
    logic acc_clr, rd_en, res_wr_en, done;
    logic clr_all, k_clr, k_inc, rc_inc;
    logic k_last, elem_last;
    logic [IDX_W-1:0] row_idx, col_idx, k_idx;

    mac_seq_idx_cnt #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_idx_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .clr_all   (clr_all),
        .k_clr     (k_clr),
        .k_inc     (k_inc),
        .rc_inc    (rc_inc),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .k_idx     (k_idx),
        .k_last    (k_last),
        .elem_last (elem_last)
    );

    assign busy      = is_busy(state_q);
    assign abort_hit = bus.abort && busy;

    always_comb begin
        state_d   = state_q;
        acc_clr   = 1'b0;
        rd_en     = 1'b0;
        res_wr_en = 1'b0;
        done      = 1'b0;
        clr_all   = 1'b0;
        k_clr     = 1'b0;
        k_inc     = 1'b0;
        rc_inc    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clr = 1'b1;
                k_clr   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en = 1'b1;
                k_inc = 1'b1;
                if (k_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                res_wr_en = 1'b1;
                rc_inc    = 1'b1;
                state_d   = elem_last ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort silences this cycle's strobes so no partial write or accumulate escapes.
        if (abort_hit) begin
            state_d   = S_IDLE;
            acc_clr   = 1'b0;
            rd_en     = 1'b0;
            res_wr_en = 1'b0;
            k_clr     = 1'b0;
            k_inc     = 1'b0;
            rc_inc    = 1'b0;
            clr_all   = 1'b1;
        end
        acc_en_d = rd_en;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_en_q <= acc_en_d;
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && bus.start) begin
            perf_d = '0;
        end else if (busy) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.acc_clr   = acc_clr;
    assign bus.rd_en     = rd_en;
    assign bus.acc_en    = acc_en_q && !abort_hit;
    assign bus.res_wr_en = res_wr_en;
    assign bus.row_idx   = row_idx;
    assign bus.col_idx   = col_idx;
    assign bus.k_idx     = k_idx;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: DIM=2 timing/abort/reset/back-to-back runs and a DIM=4
// matrix-product scoreboard driven by the sequencer strobes.
module tb_mac_sequencer;

`ifdef MAC_SEQ_PERF_CNT_EN
    localparam logic [31:0] PERF2 = 32'd20;
    localparam logic [31:0] PERF4 = 32'd112;
`else
    localparam logic [31:0] PERF2 = 32'd0;
    localparam logic [31:0] PERF4 = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mac_seq_if #(.IDX_W(1)) if2 ();
    mac_seq_if #(.IDX_W(2)) if4 ();

    mac_sequencer #(.DIM(2)) dut2 (.CLK(clk), .RST(rst), .bus(if2));
    mac_sequencer #(.DIM(4)) dut4 (.CLK(clk), .RST(rst), .bus(if4));

    // Operand memories with one-cycle read latency and a MAC fed by the strobes.
    int a_mem [4][4];
    int b_mem [4][4];
    int c_mem [4][4];
    int exp_c [4][4];
    int ra = 0, rb = 0, acc = 0, wr_cnt = 0;

    always @(negedge clk) begin
        if (if4.acc_clr)     acc <= 0;
        else if (if4.acc_en) acc <= acc + ra * rb;
        if (if4.res_wr_en) begin
            c_mem[if4.row_idx][if4.col_idx] <= acc;
            wr_cnt <= wr_cnt + 1;
        end
        if (if4.rd_en) begin
            ra <= a_mem[if4.row_idx][if4.k_idx];
            rb <= b_mem[if4.k_idx][if4.col_idx];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // {busy, done, acc_clr, rd_en, acc_en, res_wr_en}
    function automatic logic [31:0] vec2();
        return {26'd0, if2.busy, if2.done, if2.acc_clr, if2.rd_en, if2.acc_en, if2.res_wr_en};
    endfunction

    function automatic logic [31:0] idx2();
        return {29'd0, if2.row_idx, if2.col_idx, if2.k_idx};
    endfunction

    // One DIM=2 run: start seen in cycle 0, element e occupies cycles 5e+1..5e+5.
    task automatic run2(input bit hold, input string tag);
        logic [5:0] ev;
        int ph, el;
        nxt();
        if2.start = 1'b1;
        #1;
        chk({tag, "_idle"}, 32'(if2.busy), 32'd0);
        for (int c = 1; c <= 21; c++) begin
            nxt();
            if (!hold) if2.start = 1'b0;
            #1;
            ph = (c - 1) % 5;
            el = (c - 1) / 5;
            if (c <= 20) ev = {1'b1, 1'b0, ph == 0, (ph == 1) || (ph == 2), (ph == 2) || (ph == 3), ph == 4};
            else         ev = 6'b010000;
            chk($sformatf("%s_strobes_c%0d", tag, c), vec2(), 32'(ev));
            if ((c <= 20) && ((ph == 1) || (ph == 2)))
                chk($sformatf("%s_k_c%0d", tag, c), 32'(if2.k_idx), 32'(ph - 1));
            if ((c <= 20) && (ph == 4))
                chk($sformatf("%s_rowcol_c%0d", tag, c), 32'({if2.row_idx, if2.col_idx}), 32'(el));
            if (c == 21)
                chk({tag, "_perf"}, if2.perf_cycles, PERF2);
        end
    endtask

    initial begin
        int got;
        if2.start = 1'b0;
        if2.abort = 1'b0;
        if4.start = 1'b0;
        if4.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a_mem[i][j] = int'($urandom_range(1, 15));
                b_mem[i][j] = int'($urandom_range(1, 15));
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < 4; k++) exp_c[i][j] += a_mem[i][k] * b_mem[k][j];
            end
        end

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_strobes", vec2(), 32'd0);
        chk("rst_idx", idx2(), 32'd0);
        chk("rst_perf", if2.perf_cycles, 32'd0);
        chk("rst_busy4", 32'(if4.busy), 32'd0);
        rst = 1'b0;

        run2(1'b0, "run1");

        // Abort in second ISSUE cycle of element (0,1), i.e. cycle 8
        nxt();
        if2.start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            nxt();
            if2.start = 1'b0;
        end
        nxt();
        if2.abort = 1'b1;
        #1;
        chk("abort_cycle", vec2(), 32'b100000);
        nxt();
        if2.abort = 1'b0;
        #1;
        chk("abort_next_strobes", vec2(), 32'd0);
        chk("abort_next_idx", idx2(), 32'd0);
        for (int c = 0; c < 4; c++) begin
            nxt();
            #1;
            chk($sformatf("abort_quiet_%0d", c), vec2(), 32'd0);
        end

        // Abort ignored in IDLE, honoured in CLEAR
        nxt();
        if2.start = 1'b1;
        if2.abort = 1'b1;
        nxt();
        if2.start = 1'b0;
        #1;
        chk("abort_idle_ignored", vec2(), 32'b100000);
        nxt();
        if2.abort = 1'b0;
        #1;
        chk("abort_clear", vec2(), 32'd0);

        // Reset mid-DRAIN of element (1,1), cycle 19
        nxt();
        if2.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            nxt();
            if2.start = 1'b0;
        end
        nxt();
        #1;
        chk("pre_rst_drain", vec2(), 32'b100010);
        chk("pre_rst_idx", idx2(), 32'b111);
        rst = 1'b1;
        #1;
        chk("rst_async_strobes", vec2(), 32'd0);
        chk("rst_async_idx", idx2(), 32'd0);
        chk("rst_async_perf", if2.perf_cycles, 32'd0);
        #2;
        rst = 1'b0;
        nxt();
        #1;
        chk("rst_no_write", vec2(), 32'd0);
        run2(1'b0, "after_rst");

        // Back-to-back with start held high
        run2(1'b1, "b2b_a");
        run2(1'b1, "b2b_b");
        if2.start = 1'b0;

        // DIM=4 scoreboard
        nxt();
        if4.start = 1'b1;
        got = 0;
        for (int i = 0; (i < 300) && (got == 0); i++) begin
            nxt();
            if4.start = 1'b0;
            #1;
            if (if4.done) got = 1;
        end
        chk("dim4_done_seen", 32'(got), 32'd1);
        chk("dim4_perf", if4.perf_cycles, PERF4);
        chk("dim4_writes", 32'(wr_cnt), 32'd16);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("dim4_c_%0d_%0d", i, j), 32'(c_mem[i][j]), 32'(exp_c[i][j]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
